// File: rtl/ov5640_sccb_master_pkg.sv
// Shared types and constants for the OV5640 SCCB write master.
package ov5640_pkg;

  // Bus-level phases of one SCCB write transaction.
  typedef enum logic [2:0] {
    IDLE,
    START,
    BYTE,
    ACK,
    STOP
  } sccb_state_t;

  // OV5640 write ID; the R/W bit is already 0.
  localparam logic [7:0] OV5640_DEV_ADDR = 8'h78;

  // Bytes per write: device ID, addr hi, addr lo, data.
  localparam int SCCB_BYTES = 4;

  // START + bytes * (8 data + 1 ack) slots * 4 quarters + STOP.
  localparam int SCCB_QUARTERS_PER_XFER = 152;

  // SCL is high in the middle two quarters of every bit slot.
  function automatic logic scl_high(input logic [1:0] phase);
    return (phase == 2'd1) || (phase == 2'd2);
  endfunction

endpackage

// File: rtl/ov5640_sccb_master_if.sv
// Request/response handshake and SCCB pad signals of the write master.
interface ov5640_sccb_master_if;
  logic        cfg_start;
  logic [23:0] cfg_data;
  logic        cfg_end;
  logic        busy;
  logic        ack_err;
  logic        scl;
  logic        sda_out;
  logic        sda_oe;
  logic        sda_in;

  modport master (
    input  cfg_start, cfg_data, sda_in,
    output cfg_end, busy, ack_err, scl, sda_out, sda_oe
  );

  modport slave (
    output cfg_start, cfg_data, sda_in,
    input  cfg_end, busy, ack_err, scl, sda_out, sda_oe
  );
endinterface

// File: rtl/ov5640_sccb_master_quarter_tick.sv
// SCL quarter-period timer: counts 0..Q_CNT-1, ticks on wrap and tracks
// which of the four quarters of a bit slot is current.
module sccb_quarter_tick #(
  parameter int Q_CNT = 50
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       clear,
  input  logic       enable,
  output logic       tick,
  output logic [1:0] phase,
  output logic       quarter_start
);

  localparam int QW = (Q_CNT > 1) ? $clog2(Q_CNT) : 1;

  logic [QW-1:0] qcnt_reg;
  logic [1:0]    phase_reg;

  assign tick          = enable && (qcnt_reg == QW'(Q_CNT - 1));
  assign quarter_start = enable && (qcnt_reg == '0);
  assign phase         = phase_reg;

  // Quarter counter and slot phase; clear holds both at the slot origin.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || clear) begin
      qcnt_reg  <= '0;
      phase_reg <= 2'd0;
    end else if (enable) begin
      if (tick) begin
        qcnt_reg  <= '0;
        phase_reg <= phase_reg + 2'd1;
      end else begin
        qcnt_reg <= qcnt_reg + QW'(1);
      end
    end
  end

endmodule

// File: rtl/ov5640_sccb_master.sv
// SCCB write master for the OV5640 configuration sequencer: one
// {addr[15:0], value[7:0]} word per cfg_start, sent as ID/addr hi/addr lo/data
// framed by START and STOP, finished with a one-cycle cfg_end.
module ov5640_sccb_master
  import ov5640_pkg::*;
#(
  parameter int         SYS_CLK_FREQ = 50_000_000,
  parameter int         SCL_FREQ     = 250_000,
  parameter int         Q_CNT        = SYS_CLK_FREQ / (4 * SCL_FREQ),
  parameter logic [7:0] DEV_ADDR     = OV5640_DEV_ADDR
) (
  input logic                  sys_clk,
  input logic                  sys_rst,
  ov5640_sccb_master_if.master bus
);

  generate
    if (Q_CNT < 2) begin : g_qcnt_check
      $error("ov5640_sccb_master: Q_CNT must be >= 2");
    end
    if (4 + SCCB_BYTES * 9 * 4 + 4 != SCCB_QUARTERS_PER_XFER) begin : g_len_check
      $error("ov5640_sccb_master: transaction length constants disagree");
    end
  endgenerate

  sccb_state_t state_reg, state_next;

  logic [23:0] data_reg;
  logic [2:0]  bit_reg;
  logic [1:0]  byte_reg;
  logic        nack_reg;
  logic        busy_reg;
  logic        cfg_end_reg;
  logic        ack_err_reg;
  logic [1:0]  sda_sync_reg;

  logic       tick;
  logic [1:0] phase;
  logic       quarter_start;
  logic       slot_end;
  logic       accept;
  logic       cur_bit;
  logic       scl_val;
  logic       sda_oe_val;

  logic [7:0] xfer_bytes [SCCB_BYTES];

  // Byte 0 is the device ID, the rest come from the latched word, MSB first.
  genvar gi;
  generate
    for (gi = 0; gi < SCCB_BYTES; gi++) begin : g_bytes
      if (gi == 0) begin : g_id
        assign xfer_bytes[gi] = DEV_ADDR;
      end else begin : g_word
        assign xfer_bytes[gi] = data_reg[8 * (SCCB_BYTES - 1 - gi) +: 8];
      end
    end
  endgenerate

  assign accept   = (state_reg == IDLE) && bus.cfg_start;
  assign slot_end = tick && (phase == 2'd3);
  assign cur_bit  = xfer_bytes[byte_reg][3'd7 - bit_reg];

  sccb_quarter_tick #(
    .Q_CNT(Q_CNT)
  ) u_quarter_tick (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .clear         (state_reg == IDLE),
    .enable        (state_reg != IDLE),
    .tick          (tick),
    .phase         (phase),
    .quarter_start (quarter_start)
  );

  // Two-flop synchroniser on the SDA pad; the value seen at the start of q2
  // reflects the line late in q1, still well inside the ACK slot.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sda_sync_reg <= 2'b11;
    end else begin
      sda_sync_reg <= {sda_sync_reg[0], bus.sda_in};
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: every phase advances only on a completed bit slot.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (accept) state_next = START;
      START: if (slot_end) state_next = BYTE;
      BYTE:  if (slot_end && (bit_reg == 3'd7)) state_next = ACK;
      ACK:   if (slot_end) state_next = (byte_reg == 2'd3) ? STOP : BYTE;
      STOP:  if (slot_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transaction datapath: word latch, bit/byte counters, NACK flag, handshake.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      data_reg    <= '0;
      bit_reg     <= 3'd0;
      byte_reg    <= 2'd0;
      nack_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      cfg_end_reg <= 1'b0;
      ack_err_reg <= 1'b0;
    end else begin
      cfg_end_reg <= 1'b0;
      ack_err_reg <= 1'b0;
      if (accept) begin
        data_reg <= bus.cfg_data;
        busy_reg <= 1'b1;
        bit_reg  <= 3'd0;
        byte_reg <= 2'd0;
        nack_reg <= 1'b0;
      end
      if ((state_reg == BYTE) && slot_end) begin
        bit_reg <= bit_reg + 3'd1;
      end
      if (state_reg == ACK) begin
        if ((phase == 2'd2) && quarter_start && sda_sync_reg[1]) begin
          nack_reg <= 1'b1;
        end
        if (slot_end) begin
          byte_reg <= byte_reg + 2'd1;
        end
      end
      if ((state_reg == STOP) && slot_end) begin
        cfg_end_reg <= 1'b1;
        ack_err_reg <= nack_reg;
        busy_reg    <= 1'b0;
        nack_reg    <= 1'b0;
      end
    end
  end

  // Bus outputs decoded from the current phase and quarter.
  always_comb begin
    scl_val    = 1'b1;
    sda_oe_val = 1'b0;
    case (state_reg)
      IDLE: begin
        scl_val    = 1'b1;
        sda_oe_val = 1'b0;
      end
      START: begin
        scl_val    = (phase != 2'd3);
        sda_oe_val = phase[1];
      end
      BYTE: begin
        scl_val    = scl_high(phase);
        sda_oe_val = ~cur_bit;
      end
      ACK: begin
        scl_val    = scl_high(phase);
        sda_oe_val = 1'b0;
      end
      STOP: begin
        scl_val    = (phase != 2'd0);
        sda_oe_val = ~phase[1];
      end
      default: begin
        scl_val    = 1'b1;
        sda_oe_val = 1'b0;
      end
    endcase
  end

  assign bus.scl     = scl_val;
  assign bus.sda_oe  = sda_oe_val;
  assign bus.sda_out = 1'b0;
  assign bus.cfg_end = cfg_end_reg;
  assign bus.busy    = busy_reg;
  assign bus.ack_err = ack_err_reg;

endmodule
